mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory bus between the instruction-fetch port and the data-memory port.
//  It sits between the pipeline (fetch stage and MEM stage) and the unified memory.
//  It runs one transaction at a time, and each transaction is a request/grant phase followed by a response phase.
//  It tells the pipeline to stall each stage whose request has not yet been granted or answered.

---
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;

  logic          dm_req_i;
  logic          dm_we_i;
  logic [BW-1:0] dm_be_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic          dm_gnt_o;
  logic          dm_rvalid_o;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_err_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;

  logic          stall_if_o;
  logic          stall_dm_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output stall_if_o, stall_dm_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  stall_if_o, stall_dm_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported memory, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin ties; default is data-over-fetch priority.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_ni,
  mem_port_arbiter_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);
  localparam logic [DW-1:0] DEAD = DW'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  state_t        state_q;
  logic          own_dm_q;
  logic          we_q;
  logic [BW-1:0] be_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] cnt_q;

  logic          in_req;
  logic          in_rsp;
  logic          tout;
  logic          done;
  logic          any_req;
  logic          pick_dm;
  logic [DW-1:0] rsp_data;

  assign in_req  = (state_q == REQ);
  assign in_rsp  = (state_q == RSP);
  assign any_req = bus.if_req_i | bus.dm_req_i;

  // A real response in the last allowed cycle beats the timeout.
  assign tout = in_rsp & ~bus.mem_rvalid_i & (cnt_q == CMAX);
  assign done = in_rsp & (bus.mem_rvalid_i | tout);
  assign rsp_data = tout ? DEAD : bus.mem_rdata_i;

`ifdef MEM_ARB_RR_EN
  logic last_dm_q;

  assign pick_dm = bus.dm_req_i &
                   (~bus.if_req_i | ~last_dm_q);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      last_dm_q <= 1'b0;
    end else if (done) begin
      last_dm_q <= own_dm_q;
    end
  end
`else
  assign pick_dm = bus.dm_req_i;
`endif

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      own_dm_q <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            own_dm_q <= pick_dm;
            we_q     <= pick_dm & bus.dm_we_i;
            be_q     <= pick_dm ? bus.dm_be_i : '1;
            addr_q   <= pick_dm ? bus.dm_addr_i
                                : bus.if_addr_i;
            wdata_q  <= pick_dm ? bus.dm_wdata_i : '0;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_gnt_i) begin
            cnt_q   <= '0;
            state_q <= RSP;
          end
        end
        RSP: begin
          if (done) begin
            state_q <= IDLE;
          end else if (cnt_q != CMAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_o   = in_req;
  assign bus.mem_we_o    = in_req & we_q;
  assign bus.mem_be_o    = in_req ? be_q : '0;
  assign bus.mem_addr_o  = in_req ? addr_q : '0;
  assign bus.mem_wdata_o = in_req ? wdata_q : '0;

  assign bus.if_gnt_o = in_req & bus.mem_gnt_i & ~own_dm_q;
  assign bus.dm_gnt_o = in_req & bus.mem_gnt_i & own_dm_q;

  assign bus.if_rvalid_o = done & ~own_dm_q;
  assign bus.dm_rvalid_o = done & own_dm_q;
  assign bus.if_rdata_o  = bus.if_rvalid_o ? rsp_data : '0;
  assign bus.dm_rdata_o  = bus.dm_rvalid_o ? rsp_data : '0;
  assign bus.dm_err_o    = tout & own_dm_q;

  assign bus.stall_if_o = bus.if_req_i & ~bus.if_rvalid_o;
  assign bus.stall_dm_o = bus.dm_req_i & ~bus.dm_rvalid_o;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner sequences,
// then random traffic against a transaction-level memory/arbiter model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst_ni(rst_ni),
    .bus(bus)
  );

  typedef struct {
    bit          dm;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gd;
    int          rd;
    logic [31:0] rdat;
    int          eg;
    int          ev;
    logic [31:0] erd;
    bit          eerr;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_be_i = '0;
    bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
  endtask

  // One transaction with a scripted memory: gnt after gd REQ cycles,
  // rvalid rd cycles after gnt (rd<0: never). Caller is at posedge+1.
  task automatic run_txn(input vec_t v, output int gc, output int vc,
                         output logic [31:0] got, output bit err,
                         output bit f_ok, output bit o_ok,
                         output bit s_ok);
    int req_n;
    bit og, ov, xg, xv, st;
    logic [31:0] xd;
    gc = -1; vc = -1; got = '0; err = 0;
    f_ok = 1; o_ok = 1; s_ok = 1; req_n = 0;
    if (v.dm) begin
      bus.dm_req_i = 1; bus.dm_we_i = v.we; bus.dm_be_i = v.be;
      bus.dm_addr_i = v.addr; bus.dm_wdata_i = v.wdata;
    end else begin
      bus.if_req_i = 1; bus.if_addr_i = v.addr;
    end
    for (int c = 0; c < 60 && vc < 0; c++) begin
      if (c > 0) step();
      bus.mem_gnt_i = bus.mem_req_o && (req_n == v.gd);
      bus.mem_rvalid_i = (gc >= 0) && (v.rd >= 0) && (c == gc + 1 + v.rd);
      bus.mem_rdata_i = bus.mem_rvalid_i ? v.rdat : 32'h5A5A_5A5A;
      #4;
      if (bus.mem_req_o) begin
        req_n++;
        if (bus.mem_we_o !== v.we || bus.mem_be_o !== v.be ||
            bus.mem_addr_o !== v.addr || bus.mem_wdata_o !== v.wdata)
          f_ok = 0;
      end
      og = v.dm ? bus.dm_gnt_o : bus.if_gnt_o;
      ov = v.dm ? bus.dm_rvalid_o : bus.if_rvalid_o;
      xg = v.dm ? bus.if_gnt_o : bus.dm_gnt_o;
      xv = v.dm ? bus.if_rvalid_o : bus.dm_rvalid_o;
      xd = v.dm ? bus.if_rdata_o : bus.dm_rdata_o;
      st = v.dm ? bus.stall_dm_o : bus.stall_if_o;
      if (xg || xv || xd != 0 || (!v.dm && bus.dm_err_o)) o_ok = 0;
      if (st !== !ov) s_ok = 0;
      if (og) gc = c;
      if (ov) begin
        vc = c;
        got = v.dm ? bus.dm_rdata_o : bus.if_rdata_o;
        err = bus.dm_err_o;
      end
    end
    step();
    idle_in();
  endtask

  int gc, vc;
  logic [31:0] got;
  bit err, f_ok, o_ok, s_ok;

  // random-phase model state
  bit m_act, m_gnted, m_own, m_drop;
  int m_rsp;
  logic [31:0] m_val, ed;
  bit p_free, p_if, p_dm, if_done, dm_done, exp_g, exp_v, real_rv;

  initial begin
    tbl[0] = '{0, 0, 4'hF, 32'h100, 0, 0, 0, 32'h13,
               1, 2, 32'h13, 0};
    tbl[1] = '{1, 1, 4'h3, 32'h200, 32'hCAFE, 0, 0, 0,
               1, 2, 0, 0};
    tbl[2] = '{1, 0, 4'hF, 32'h300, 0, 5, 0, 32'h1234,
               6, 7, 32'h1234, 0};
    tbl[3] = '{0, 0, 4'hF, 32'h104, 0, 2, 3, 32'hABCD,
               3, 7, 32'hABCD, 0};
    tbl[4] = '{1, 0, 4'hF, 32'h400, 0, 0, -1, 0,
               1, 17, 32'hDEAD_BEEF, 1};
    tbl[5] = '{0, 0, 4'hF, 32'h108, 0, 1, -1, 0,
               2, 18, 32'hDEAD_BEEF, 0};
    tbl[6] = '{1, 0, 4'hC, 32'h500, 0, 0, 14, 32'h600D_F00D,
               1, 16, 32'h600D_F00D, 0};

    idle_in();
    step();
    #4;
    chk("rst_mem", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_hs", {bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o,
                   bus.dm_rvalid_o, bus.dm_err_o}, 0);
    step();
    rst_ni = 1;
    step();

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i], gc, vc, got, err, f_ok, o_ok, s_ok);
      chk($sformatf("v%0d_gnt_cyc", i), gc, tbl[i].eg);
      chk($sformatf("v%0d_rv_cyc", i), vc, tbl[i].ev);
      chk($sformatf("v%0d_rdata", i), got, tbl[i].erd);
      chk($sformatf("v%0d_err", i), err, tbl[i].eerr);
      chk($sformatf("v%0d_fields", i), f_ok, 1);
      chk($sformatf("v%0d_other", i), o_ok, 1);
      chk($sformatf("v%0d_stall", i), s_ok, 1);
    end

    // tie: data first, fetch in the following REQ
    bus.dm_req_i = 1; bus.dm_addr_i = 32'h700; bus.dm_be_i = 4'hF;
    bus.if_req_i = 1; bus.if_addr_i = 32'h800;
    step();
    bus.mem_gnt_i = 1;
    #4;
    chk("tie_dm_gnt", bus.dm_gnt_o, 1);
    chk("tie_if_gnt0", bus.if_gnt_o, 0);
    chk("tie_addr1", bus.mem_addr_o, 32'h700);
    step();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h77;
    #4;
    chk("tie_dm_rv", {bus.dm_rvalid_o, bus.if_rvalid_o}, 2'b10);
    chk("tie_dm_rd", bus.dm_rdata_o, 32'h77);
    step();
    bus.dm_req_i = 0; bus.mem_rvalid_i = 0;
    #4;
    chk("tie_gap", bus.mem_req_o, 0);
    step();
    bus.mem_gnt_i = 1;
    #4;
    chk("tie_if_gnt", {bus.if_gnt_o, bus.dm_gnt_o}, 2'b10);
    chk("tie_addr2", {bus.mem_addr_o, bus.mem_be_o}, {32'h800, 4'hF});
    step();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h88;
    #4;
    chk("tie_if_rd", bus.if_rdata_o, 32'h88);
    chk("tie_stall", bus.stall_if_o, 0);
    step();
    idle_in();
    step();

    // reset while waiting in RSP; the late response must vanish
    bus.dm_req_i = 1; bus.dm_addr_i = 32'h900; bus.dm_be_i = 4'hF;
    step();
    bus.mem_gnt_i = 1;
    #4;
    chk("rr_gnt", bus.dm_gnt_o, 1);
    step();
    idle_in();
    rst_ni = 0;
    #1;
    chk("rr_out0", {bus.mem_req_o, bus.dm_gnt_o, bus.dm_rvalid_o,
                    bus.if_rvalid_o, bus.dm_err_o}, 0);
    step();
    rst_ni = 1;
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1111;
    #4;
    chk("rr_late", {bus.dm_rvalid_o, bus.if_rvalid_o, bus.mem_req_o}, 0);
    step();
    idle_in();
    step();
    run_txn('{0, 0, 4'hF, 32'hA00, 0, 0, 0, 32'h42, 0, 0, 0, 0},
            gc, vc, got, err, f_ok, o_ok, s_ok);
    chk("rr_next_gnt", gc, 1);
    chk("rr_next_rv", vc, 2);
    chk("rr_next_rd", got, 32'h42);

    // random traffic; the model tracks whole transactions only
    m_act = 0; m_gnted = 0; m_own = 0; m_drop = 0; m_rsp = 0;
    m_val = 0; p_free = 1; p_if = 0; p_dm = 0;
    if_done = 0; dm_done = 0;
    for (int t = 0; t < 3000; t++) begin
      if (if_done) begin
        bus.if_req_i = 0; if_done = 0;
      end else if (!bus.if_req_i && $urandom_range(2) == 0) begin
        bus.if_req_i = 1; bus.if_addr_i = $urandom;
      end
      if (dm_done) begin
        bus.dm_req_i = 0; dm_done = 0;
      end else if (!bus.dm_req_i && $urandom_range(3) == 0) begin
        bus.dm_req_i = 1; bus.dm_we_i = 1'($urandom);
        bus.dm_be_i = 4'($urandom); bus.dm_addr_i = $urandom;
        bus.dm_wdata_i = $urandom;
      end
      bus.mem_gnt_i = 1'($urandom);
      real_rv = m_gnted && !m_drop && (t == m_rsp);
      bus.mem_rvalid_i = real_rv || (!m_gnted && $urandom_range(7) == 0);
      bus.mem_rdata_i = real_rv ? m_val : $urandom;
      #4;
      if (p_free && (p_if || p_dm)) begin
        m_act = 1; m_gnted = 0; m_own = p_dm;
      end
      chk("r_req", bus.mem_req_o, m_act && !m_gnted);
      if (m_act && !m_gnted) begin
        chk("r_addr", bus.mem_addr_o,
            m_own ? bus.dm_addr_i : bus.if_addr_i);
        chk("r_ctl", {bus.mem_we_o, bus.mem_be_o},
            m_own ? {bus.dm_we_i, bus.dm_be_i} : {1'b0, 4'hF});
        chk("r_wdata", bus.mem_wdata_o, m_own ? bus.dm_wdata_i : 0);
      end
      exp_g = m_act && !m_gnted && bus.mem_gnt_i;
      chk("r_gnt", {bus.if_gnt_o, bus.dm_gnt_o},
          {exp_g && !m_own, exp_g && m_own});
      exp_v = m_gnted && (t == m_rsp);
      ed = exp_v ? (m_drop ? 32'hDEAD_BEEF : m_val) : 0;
      chk("r_rv", {bus.if_rvalid_o, bus.dm_rvalid_o, bus.dm_err_o},
          {exp_v && !m_own, exp_v && m_own, exp_v && m_own && m_drop});
      chk("r_ifrd", bus.if_rdata_o, m_own ? 0 : ed);
      chk("r_dmrd", bus.dm_rdata_o, m_own ? ed : 0);
      chk("r_stall", {bus.stall_if_o, bus.stall_dm_o},
          {bus.if_req_i && !(exp_v && !m_own),
           bus.dm_req_i && !(exp_v && m_own)});
      p_free = !m_act;
      p_if = bus.if_req_i;
      p_dm = bus.dm_req_i;
      if (exp_g) begin
        m_gnted = 1;
        m_drop = ($urandom_range(7) == 0);
        m_rsp = m_drop ? t + 16 : t + 1 + int'($urandom_range(14));
        m_val = $urandom;
      end
      if (exp_v) begin
        m_act = 0; m_gnted = 0;
        if (m_own) dm_done = 1;
        else if_done = 1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
